inst_fetch_ctrl: RTL

Instruction-fetch initiator for the multi-cycle instruction memory port (cs / addr / dout / stall handshake). It owns the program counter, issues word requests, waits out memory stall, and buffers one fetched instruction toward the decode stage with a valid/ready handshake. It supports branch/exception redirect that aborts an in-flight fetch. It also reports slow-memory timeouts and misaligned redirect targets.

---
 rtl/inst_fetch_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch initiator: owns the PC, drives the cs/addr/stall memory port and
// buffers one fetched word toward decode behind a valid/ready handshake.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_cs,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic        mem_stall,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        fetch_timeout,
  output logic        misaligned
);

  typedef enum logic [1:0] {GAP, FETCH, HOLD} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ipc_q, ipc_d;
  logic        to_q, to_d;
  logic        mis_q, mis_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GAP;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      to_q    <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      to_q    <= to_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    to_d    = to_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    // Redirect wins over everything: an access completing this cycle is dropped.
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      state_d = GAP;
      if (redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
    end else begin
      case (state_q)
        GAP: begin
          state_d = FETCH;
          cnt_d   = '0;
        end
        FETCH: begin
          if (!mem_stall) begin
            data_d  = mem_dout;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = HOLD;
          end else begin
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            if (cnt_d == TO_LIM) to_d = 1'b1;
          end
        end
        HOLD: begin
          if (valid_q && inst_ready) begin
            valid_d = 1'b0;
            state_d = FETCH;
            cnt_d   = '0;
          end
        end
        default: state_d = GAP;
      endcase
    end
  end

  assign mem_cs        = (state_q == FETCH);
  assign busy          = (state_q == FETCH);
  assign mem_addr      = {2'b00, pc_q[31:2]};
  assign inst_valid    = valid_q;
  assign inst_data     = data_q;
  assign inst_pc       = ipc_q;
  assign fetch_timeout = to_q;
  assign misaligned    = mis_q;

endmodule
